heat_power_sequencer: RTL and testbench

HEAT_POWER_SEQUENCER -- requirements
Module: heat_power_sequencer

---
 rtl/heat_power_sequencer.sv | 136 +++++++++++++
 tb/tb_heat_power_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/heat_power_sequencer.sv
// Cook timer with IDLE/RUN/PAUSE/DONE sequencing and a one-second prescaler.
// Define HEAT_DUTY_EN to duty-cycle the magnetron over 10 s windows by heat level.
module heat_power_sequencer #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        load_time,
  input  logic [15:0] time_in,
  input  logic        load_level,
  input  logic [1:0]  level_in,
  input  logic        run,
  input  logic        clear,
  output logic        magnetron_on,
  output logic [15:0] time_left,
  output logic [1:0]  level_out,
  output logic        done_count,
  output logic        busy
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_time_left;
  logic [1:0]  r_level;
  logic [PW-1:0] r_presc;
  logic        w_advance;
  logic        w_tick;
  logic        w_load_ok;

  // The prescaler only moves while actually running; dropping run freezes it mid-second.
  assign w_advance = (r_state == S_RUN) && run && !clear;
  assign w_tick    = w_advance && (r_presc == PRESC_MAX);
  assign w_load_ok = load_time && ((r_state == S_IDLE) || (r_state == S_DONE));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // NOTE: default assignment first so no path leaves w_next_state unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A same-cycle load wins; run is re-evaluated against the new time next cycle.
          if (load_time)  w_next_state = S_IDLE;
          else if (run)   w_next_state = (r_time_left != '0) ? S_RUN : S_DONE;
        end
        S_RUN: begin
          if (!run)                                  w_next_state = S_PAUSE;
          else if (w_tick && r_time_left == 16'd1)   w_next_state = S_DONE;
        end
        S_PAUSE: begin
          if (run) w_next_state = S_RUN;
        end
        S_DONE: begin
          if (load_time) w_next_state = S_IDLE;
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_time_left <= '0;
      r_level     <= '0;
      r_presc     <= '0;
    end else if (clear) begin
      r_time_left <= '0;
      r_presc     <= '0;
    end else begin
      if (load_level) r_level <= level_in;
      if (w_load_ok)  r_time_left <= time_in;
      if (w_advance) begin
        if (w_tick) begin
          r_presc <= '0;
          if (r_time_left != '0) r_time_left <= r_time_left - 16'd1;
        end else begin
          r_presc <= r_presc + 1'b1;
        end
      end
    end
  end

`ifdef HEAT_DUTY_EN
  logic [3:0] r_phase;
  logic [3:0] w_on_secs;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                   r_phase <= '0;
    else if (clear)                r_phase <= '0;
    else if (w_tick)               r_phase <= (r_phase == 4'd9) ? 4'd0 : r_phase + 4'd1;
  end

  // Seconds of magnetron-on per 10 s window, by heat level.
  always_comb begin
    case (r_level)
      2'b11:   w_on_secs = 4'd10;
      2'b10:   w_on_secs = 4'd7;
      2'b01:   w_on_secs = 4'd5;
      default: w_on_secs = 4'd3;
    endcase
  end

  always_comb begin
    magnetron_on = (r_state == S_RUN) && (r_phase < w_on_secs);
    busy         = (r_state == S_RUN) || (r_state == S_PAUSE);
    done_count   = (r_state == S_DONE);
  end
`else
  always_comb begin
    magnetron_on = (r_state == S_RUN);
    busy         = (r_state == S_RUN) || (r_state == S_PAUSE);
    done_count   = (r_state == S_DONE);
  end
`endif

  assign time_left = r_time_left;
  assign level_out = r_level;

endmodule

// File: tb/tb_heat_power_sequencer.sv
// Self-checking bench for heat_power_sequencer (TICK_DIV=4): directed scenarios
// plus randomized traffic against a seconds-and-cycles reference model.
module tb_heat_power_sequencer;

  localparam int TICK_DIV = 4;

  logic        clock = 1'b0;
  logic        resetn = 1'b1;
  logic        load_time = 1'b0;
  logic [15:0] time_in = '0;
  logic        load_level = 1'b0;
  logic [1:0]  level_in = '0;
  logic        run = 1'b0;
  logic        clear = 1'b0;
  logic        magnetron_on;
  logic [15:0] time_left;
  logic [1:0]  level_out;
  logic        done_count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  heat_power_sequencer #(.TICK_DIV(TICK_DIV)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .load_time    (load_time),
    .time_in      (time_in),
    .load_level   (load_level),
    .level_in     (level_in),
    .run          (run),
    .clear        (clear),
    .magnetron_on (magnetron_on),
    .time_left    (time_left),
    .level_out    (level_out),
    .done_count   (done_count),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  // Reference model: mode, remaining seconds, cycles into the current second,
  // and whole seconds cooked since the last clear (window position = secs % 10).
  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mode_t;
  mode_t m_mode;
  int    m_time;
  int    m_level;
  int    m_sub;
  int    m_secs;
  int    on_tbl [4] = '{3, 5, 7, 10};

  task automatic model_reset();
    m_mode = M_IDLE; m_time = 0; m_level = 0; m_sub = 0; m_secs = 0;
  endtask

  task automatic model_step();
    if (clear) begin
      m_mode = M_IDLE; m_time = 0; m_sub = 0; m_secs = 0;
    end else begin
      if (load_level) m_level = int'(level_in);
      case (m_mode)
        M_IDLE: begin
          if (load_time) m_time = int'(time_in);
          else if (run)  m_mode = (m_time > 0) ? M_RUN : M_DONE;
        end
        M_RUN: begin
          if (!run) m_mode = M_PAUSE;
          else if (m_sub == TICK_DIV - 1) begin
            m_sub = 0;
            m_secs++;
            if (m_time == 1) m_mode = M_DONE;
            if (m_time > 0)  m_time--;
          end else m_sub++;
        end
        M_PAUSE: if (run) m_mode = M_RUN;
        M_DONE: begin
          if (load_time) begin m_time = int'(time_in); m_mode = M_IDLE; end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  function automatic logic exp_mag();
`ifdef HEAT_DUTY_EN
    return (m_mode == M_RUN) && ((m_secs % 10) < on_tbl[m_level]);
`else
    return (m_mode == M_RUN);
`endif
  endfunction

  task automatic set_in(input logic a_lt, input int a_t, input logic a_ll,
                        input int a_l, input logic a_run, input logic a_clr);
    load_time = a_lt; time_in = 16'(a_t); load_level = a_ll;
    level_in = 2'(a_l); run = a_run; clear = a_clr;
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #1;
    checks++;
    if ({magnetron_on, time_left, level_out, done_count, busy} !== 21'd0) begin
      errors++;
      $display("FAIL reset_async got %h want 0", {magnetron_on, time_left, level_out, done_count, busy});
    end
    model_reset();
    step();
    #2 resetn = 1'b1;
    step();
    checks++;
    if ({magnetron_on, time_left, level_out, done_count, busy} !== 21'd0) begin
      errors++;
      $display("FAIL reset_release got %h want 0", {magnetron_on, time_left, level_out, done_count, busy});
    end
  endtask

  task automatic test_full_power();
    int bad = 0;
    set_in(0, 0, 0, 0, 0, 1); step();
    set_in(1, 5, 1, 3, 0, 0); step();
    set_in(0, 0, 0, 0, 1, 0); step();
    checks++;
    if (busy !== 1'b1 || time_left !== 16'd5 || level_out !== 2'b11) begin
      errors++;
      $display("FAIL full_start busy=%b time=%0d lvl=%b want 1 5 11", busy, time_left, level_out);
    end
    for (int i = 0; i < 20; i++) begin
      if (magnetron_on !== 1'b1 || time_left !== 16'(5 - i / 4) || busy !== 1'b1) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL full_run bad_cycles=%0d want 0", bad);
    end
    checks++;
    if (done_count !== 1'b1 || busy !== 1'b0 || time_left !== 16'd0 || magnetron_on !== 1'b0) begin
      errors++;
      $display("FAIL full_done done=%b busy=%b time=%0d mag=%b want 1 0 0 0",
               done_count, busy, time_left, magnetron_on);
    end
  endtask

  task automatic test_low_duty();
    int bad = 0;
    logic exp;
    set_in(0, 0, 0, 0, 0, 1); step();
    set_in(1, 10, 1, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 1, 0); step();
    for (int i = 0; i < 40; i++) begin
`ifdef HEAT_DUTY_EN
      exp = (i < 12);
`else
      exp = 1'b1;
`endif
      if (magnetron_on !== exp || busy !== 1'b1) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL low_duty bad_cycles=%0d want 0", bad);
    end
    checks++;
    if (done_count !== 1'b1 || level_out !== 2'b00 || magnetron_on !== 1'b0) begin
      errors++;
      $display("FAIL low_done done=%b lvl=%b mag=%b want 1 00 0", done_count, level_out, magnetron_on);
    end
  endtask

  task automatic test_pause();
    int bad = 0;
    set_in(0, 0, 0, 0, 0, 1); step();
    set_in(1, 6, 1, 2, 0, 0); step();
    set_in(0, 0, 0, 0, 1, 0); step();
    repeat (8) step();
    checks++;
    if (time_left !== 16'd4 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pause_pre time=%0d busy=%b want 4 1", time_left, busy);
    end
    run = 1'b0; step();
    for (int i = 0; i < 30; i++) begin
      if (time_left !== 16'd4 || magnetron_on !== 1'b0 || busy !== 1'b1 || done_count !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL pause_hold bad_cycles=%0d want 0", bad);
    end
    run = 1'b1; step();
    repeat (15) step();
    checks++;
    if (time_left !== 16'd1 || busy !== 1'b1 || done_count !== 1'b0) begin
      errors++;
      $display("FAIL pause_resume time=%0d busy=%b done=%b want 1 1 0", time_left, busy, done_count);
    end
    step();
    checks++;
    if (time_left !== 16'd0 || done_count !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pause_done time=%0d done=%b busy=%b want 0 1 0", time_left, done_count, busy);
    end
  endtask

  task automatic test_clear_and_ignored_load();
    set_in(0, 0, 0, 0, 0, 1); step();
    set_in(1, 5, 1, 1, 0, 0); step();
    set_in(0, 0, 0, 0, 1, 0); step();
    set_in(1, 999, 0, 0, 1, 0); step();
    checks++;
    if (time_left !== 16'd5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL run_load_ignored time=%0d busy=%b want 5 1", time_left, busy);
    end
    set_in(0, 0, 0, 0, 1, 0);
    repeat (7) step();
    checks++;
    if (time_left !== 16'd3) begin
      errors++;
      $display("FAIL clear_pre time=%0d want 3", time_left);
    end
    clear = 1'b1; step();
    checks++;
    if (busy !== 1'b0 || done_count !== 1'b0 || time_left !== 16'd0 ||
        magnetron_on !== 1'b0 || level_out !== 2'b01) begin
      errors++;
      $display("FAIL clear_run busy=%b done=%b time=%0d mag=%b lvl=%b want 0 0 0 0 01",
               busy, done_count, time_left, magnetron_on, level_out);
    end
    clear = 1'b0; run = 1'b0;
  endtask

  task automatic test_zero_and_async_reset();
    int bad = 0;
    set_in(0, 0, 0, 0, 0, 1); step();
    set_in(1, 0, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 1, 0); step();
    for (int i = 0; i < 4; i++) begin
      if (done_count !== 1'b1 || busy !== 1'b0 || magnetron_on !== 1'b0 || time_left !== 16'd0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL zero_time_done bad_cycles=%0d want 0", bad);
    end
    set_in(1, 3, 0, 0, 1, 0); step();
    checks++;
    if (busy !== 1'b0 || done_count !== 1'b0 || time_left !== 16'd3) begin
      errors++;
      $display("FAIL load_run_same busy=%b done=%b time=%0d want 0 0 3", busy, done_count, time_left);
    end
    set_in(0, 0, 0, 0, 1, 0); step();
    checks++;
    if (busy !== 1'b1 || magnetron_on !== 1'b1) begin
      errors++;
      $display("FAIL load_run_next busy=%b mag=%b want 1 1", busy, magnetron_on);
    end
    repeat (2) step();
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({magnetron_on, time_left, level_out, done_count, busy} !== 21'd0) begin
      errors++;
      $display("FAIL reset_mid_run got %h want 0", {magnetron_on, time_left, level_out, done_count, busy});
    end
    model_reset();
    run = 1'b0;
    #1 resetn = 1'b1;
    step();
    checks++;
    if ({magnetron_on, time_left, level_out, done_count, busy} !== 21'd0) begin
      errors++;
      $display("FAIL reset_mid_release got %h want 0", {magnetron_on, time_left, level_out, done_count, busy});
    end
  endtask

  task automatic test_random();
    int t;
    int shown = 0;
    set_in(0, 0, 0, 0, 0, 1); step();
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 3))
        0:       t = 0;
        1:       t = 1;
        default: t = int'($urandom_range(2, 9));
      endcase
      set_in($urandom_range(0, 15) == 0, t, $urandom_range(0, 7) == 0,
             int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
             $urandom_range(0, 79) == 0);
      step();
      checks++;
      if (time_left !== 16'(m_time) || level_out !== 2'(m_level) ||
          magnetron_on !== exp_mag() ||
          busy !== (m_mode == M_RUN || m_mode == M_PAUSE) ||
          done_count !== (m_mode == M_DONE)) begin
        errors++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random cyc=%0d got t=%0d l=%0d m=%b b=%b d=%b want t=%0d l=%0d m=%b mode=%0d",
                   i, time_left, level_out, magnetron_on, busy, done_count,
                   m_time, m_level, exp_mag(), int'(m_mode));
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_power();
    test_low_duty();
    test_pause();
    test_clear_and_ignored_load();
    test_zero_and_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
